// File: rtl/rv_alu_logic.sv
// rv_alu_logic
// Integer ALU for the single-cycle RV32I datapath. One of ten arithmetic,
// logic, shift or compare operations is selected by alu_op and the result is
// registered once together with a valid strobe, a zero flag and an
// illegal-opcode flag.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands/opcode valid this cycle
//   op1        in   first operand (rs1 / PC)
//   op2        in   second operand (rs2 / immediate)
//   alu_op     in   operation select (0..9 defined, 10..15 illegal)
//   result     out  registered result
//   out_valid  out  result valid strobe (in_valid delayed one cycle)
//   zero       out  registered (result == 0)
//   illegal_op out  registered: captured alu_op was not a defined code
module rv_alu_logic #(
  parameter int ALU_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [ALU_WIDTH-1:0] op1,
  input  logic [ALU_WIDTH-1:0] op2,
  input  logic [3:0]           alu_op,
  output logic [ALU_WIDTH-1:0] result,
  output logic                 out_valid,
  output logic                 zero,
  output logic                 illegal_op
);

  localparam int SHW = $clog2(ALU_WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  // Compare results are a single bit zero-extended to the full width.
  function automatic logic [ALU_WIDTH-1:0] flag_ext(input logic f);
    flag_ext = {{(ALU_WIDTH-1){1'b0}}, f};
  endfunction

  logic signed [ALU_WIDTH-1:0] op1_s;
  logic signed [ALU_WIDTH-1:0] op2_s;
  logic        [SHW-1:0]       shamt;
  logic        [ALU_WIDTH-1:0] res_p0;
  logic                        ill_p0;

  logic        [ALU_WIDTH-1:0] result_p1;
  logic                        vld_p1;
  logic                        zero_p1;
  logic                        ill_p1;

  assign op1_s = op1;
  assign op2_s = op2;
  // Only the low SHW bits of op2 select the shift distance.
  assign shamt = op2[SHW-1:0];

  // ---- stage p0: combinational operation select ----
  always_comb begin
    res_p0 = '0;
    ill_p0 = 1'b0;
    case (alu_op)
      OP_ADD:  res_p0 = op1 + op2;
      OP_SUB:  res_p0 = op1 - op2;
      OP_SLL:  res_p0 = op1 << shamt;
      OP_SLT:  res_p0 = flag_ext(op1_s < op2_s);
      OP_SLTU: res_p0 = flag_ext(op1 < op2);
      OP_XOR:  res_p0 = op1 ^ op2;
      OP_SRL:  res_p0 = op1 >> shamt;
      OP_SRA:  res_p0 = op1_s >>> shamt;
      OP_OR:   res_p0 = op1 | op2;
      OP_AND:  res_p0 = op1 & op2;
      default: begin
        res_p0 = '0;
        ill_p0 = 1'b1;
      end
    endcase
  end

  // ---- stage p1: output register ----
  // Data and flags only update on a valid input; otherwise they hold while
  // out_valid drops. Reset value of zero is 1 because result resets to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p1 <= '0;
      vld_p1    <= 1'b0;
      zero_p1   <= 1'b1;
      ill_p1    <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        result_p1 <= res_p0;
        zero_p1   <= (res_p0 == '0);
        ill_p1    <= ill_p0;
      end
    end
  end

  assign result     = result_p1;
  assign out_valid  = vld_p1;
  assign zero       = zero_p1;
  assign illegal_op = ill_p1;

endmodule

// File: tb/tb_rv_alu_logic.sv
module tb_rv_alu_logic;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [3:0]  alu_op = '0;
  logic [31:0] result;
  logic        out_valid;
  logic        zero;
  logic        illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference output state, updated from the operation rules below.
  logic [31:0] exp_result = '0;
  logic        exp_zero   = 1'b1;
  logic        exp_ill    = 1'b0;
  logic        exp_vld    = 1'b0;

  rv_alu_logic #(.ALU_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .op1(op1), .op2(op2), .alu_op(alu_op),
    .result(result), .out_valid(out_valid), .zero(zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Behavioural reference: plain integer arithmetic on 64-bit values.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] r, output logic ill);
    longint unsigned ua, ub, p, t;
    longint sa, q;
    int sh;
    ua = a; ub = b;
    sa = longint'(int'(a));
    sh = int'(b % 32);
    p = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    ill = 1'b0;
    r = '0;
    case (op)
      4'd0: begin t = (ua + ub) % 64'h1_0000_0000; r = t[31:0]; end
      4'd1: begin t = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000; r = t[31:0]; end
      4'd2: begin t = (ua * p) % 64'h1_0000_0000; r = t[31:0]; end
      4'd3: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd4: r = (ua < ub) ? 32'd1 : 32'd0;
      4'd5: r = a ^ b;
      4'd6: begin t = ua / p; r = t[31:0]; end
      4'd7: begin
        if (sa >= 0) q = sa / longint'(p);
        else q = -((-sa + longint'(p) - 1) / longint'(p));
        r = q[31:0];
      end
      4'd8: r = a | b;
      4'd9: r = a & b;
      default: begin r = '0; ill = 1'b1; end
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".result"}, result, exp_result);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_vld});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, ".illegal_op"}, {31'd0, illegal_op}, {31'd0, exp_ill});
  endtask

  // Drive one cycle on the falling edge, check #1 after the rising edge.
  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic ill;
    @(negedge clk);
    in_valid = v; alu_op = op; op1 = a; op2 = b;
    @(posedge clk);
    #1;
    exp_vld = v;
    if (v) begin
      model(op, a, b, r, ill);
      exp_result = r;
      exp_zero   = (r == 32'd0);
      exp_ill    = ill;
    end
    check_all(tag);
  endtask

  initial begin
    // Reset state
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases with explicit expected values as well as the model
    step("add", 1, 4'd0, 32'd10, 32'd5);          chk("add15", result, 32'd15);
    step("sub", 1, 4'd1, 32'd10, 32'd5);          chk("sub5", result, 32'd5);
    step("sub0", 1, 4'd1, 32'd5, 32'd5);          chk("sub0z", {31'd0, zero}, 32'd1);
    step("addwrap", 1, 4'd0, 32'hFFFFFFFF, 32'd1); chk("wrap0", result, 32'd0);
    step("slt_neg", 1, 4'd3, 32'hFFFFFFFE, 32'd1); chk("slt1", result, 32'd1);
    step("slt", 1, 4'd3, 32'd2, 32'd5);           chk("slt2", result, 32'd1);
    step("sltu", 1, 4'd4, 32'd5, 32'd2);          chk("sltu0", result, 32'd0);
    step("sltu2", 1, 4'd4, 32'd2, 32'd5);         chk("sltu1", result, 32'd1);
    step("sltu_big", 1, 4'd4, 32'hFFFFFFFE, 32'd1); chk("sltubig", result, 32'd0);
    step("sll", 1, 4'd2, 32'd8, 32'd1);           chk("sll16", result, 32'd16);
    step("srl", 1, 4'd6, 32'hF0000000, 32'd4);    chk("srl", result, 32'h0F000000);
    step("sra", 1, 4'd7, 32'hFFFFFFE0, 32'd2);    chk("sra", result, 32'hFFFFFFF8);
    step("sll33", 1, 4'd2, 32'd1, 32'd33);        chk("sll33", result, 32'd2);
    step("sll0", 1, 4'd2, 32'h12345678, 32'd0);   chk("sll0", result, 32'h12345678);
    step("xor", 1, 4'd5, 32'd8, 32'd3);           chk("xor11", result, 32'd11);
    step("or", 1, 4'd8, 32'd12, 32'd5);           chk("or13", result, 32'd13);
    step("and", 1, 4'd9, 32'd15, 32'd5);          chk("and5", result, 32'd5);
    step("illegal", 1, 4'd15, 32'd123, 32'd0);    chk("ill1", {31'd0, illegal_op}, 32'd1);

    // Handshake: alternate valid; held values while idle with changing inputs
    step("hs1", 1, 4'd0, 32'd100, 32'd23);
    step("hs0", 0, 4'd1, 32'd7, 32'd9);
    chk("hold", result, 32'd123);
    step("hs0b", 0, 4'd15, 32'd0, 32'd0);
    step("hs2", 1, 4'd5, 32'hA5A5A5A5, 32'h5A5A5A5A);
    step("hs3", 1, 4'd9, 32'hFFFF0000, 32'h00FF00FF);

    // Randomized operations including illegal codes and idle cycles
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) a = b;
      step("rand", logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), a, b);
    end

    // Asynchronous reset mid-cycle after a nonzero result
    step("prerst", 1, 4'd0, 32'd40, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    exp_result = '0; exp_vld = 1'b0; exp_zero = 1'b1; exp_ill = 1'b0;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("postrst", 1, 4'd1, 32'd3, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
